// File: rtl/ans_delay_event_gen.sv
// Answer-delay event front-end: 10 MHz tick, TX-done pulse, filtered RX start pulse (+ answer timeout with ANS_TIMEOUT_EN).
// Latency: tick/SendFinished one clk after the sampling edge, DataReceived FILTER_LEN+3 clks after rx_i is first sampled low.
// Backpressure: none; pulses are single-cycle and must be consumed downstream in that cycle.
module ans_delay_event_gen #(
  parameter int unsigned CLK_FREQ_HZ   = 40_000_000,
  parameter int unsigned TICK_FREQ_HZ  = 10_000_000,
  parameter int unsigned FILTER_LEN    = 3,
  parameter int unsigned TIMEOUT_TICKS = 999
) (
  input  logic clk,
  input  logic rst,
  input  logic tx_busy_i,
  input  logic tx_fifo_empty_i,
  input  logic rx_i,
  output logic p_sig_10MHz_o,
  output logic p_SendFinished_o,
  output logic p_DataReceived_o,
  output logic rx_armed_o,
  output logic p_timeout_o
);

  if (CLK_FREQ_HZ < 2 * TICK_FREQ_HZ) begin : g_bad_freq
    $error("CLK_FREQ_HZ must be at least twice TICK_FREQ_HZ");
  end
  if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filter
    $error("FILTER_LEN must be in 1..15");
  end
  if (TIMEOUT_TICKS < 1 || TIMEOUT_TICKS > 65535) begin : g_bad_timeout
    $error("TIMEOUT_TICKS must fit the 16-bit answer counter");
  end

  localparam logic [31:0] TICK_INC = 32'(TICK_FREQ_HZ);
  localparam logic [31:0] CLK_MOD  = 32'(CLK_FREQ_HZ);
  localparam logic [3:0]  FILT_N   = 4'(FILTER_LEN);

  typedef enum logic [1:0] {IDLE, TX_ACTIVE, WAIT_ANS} state_t;

  logic [31:0] acc;
  logic [32:0] acc_sum;
  logic [31:0] acc_wrap;
  logic        rx_s1, rx_s2, rx_filt, rx_filt_d;
  logic [3:0]  filt_cnt;
  logic        start_evt;
  state_t      state;

  // Phase accumulator: the remainder carries over, so the tick period averages out exactly.
  assign acc_sum  = {1'b0, acc} + {1'b0, TICK_INC};
  assign acc_wrap = acc_sum[31:0] - CLK_MOD;

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc           <= '0;
      p_sig_10MHz_o <= 1'b0;
    end else if (acc_sum >= {1'b0, CLK_MOD}) begin
      acc           <= acc_wrap;
      p_sig_10MHz_o <= 1'b1;
    end else begin
      acc           <= acc_sum[31:0];
      p_sig_10MHz_o <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_filt   <= 1'b1;
      rx_filt_d <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      rx_s1     <= rx_i;
      rx_s2     <= rx_s1;
      rx_filt_d <= rx_filt;
      if (rx_s2 != rx_filt) begin
        if (filt_cnt + 4'd1 == FILT_N) begin
          rx_filt  <= rx_s2;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 4'd1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign start_evt = rx_filt_d & ~rx_filt;

`ifdef ANS_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_N = 16'(TIMEOUT_TICKS);
  logic [15:0] ans_cnt;
  logic        timeout_q;
  assign p_timeout_o = timeout_q;
`else
  assign p_timeout_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      p_SendFinished_o <= 1'b0;
      p_DataReceived_o <= 1'b0;
`ifdef ANS_TIMEOUT_EN
      ans_cnt          <= '0;
      timeout_q        <= 1'b0;
`endif
    end else begin
      p_SendFinished_o <= 1'b0;
      p_DataReceived_o <= 1'b0;
`ifdef ANS_TIMEOUT_EN
      timeout_q        <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (tx_busy_i) state <= TX_ACTIVE;
        end
        TX_ACTIVE: begin
          // Busy dropping with bytes still queued is only an inter-byte gap.
          if (!tx_busy_i && tx_fifo_empty_i) begin
            p_SendFinished_o <= 1'b1;
            state            <= WAIT_ANS;
`ifdef ANS_TIMEOUT_EN
            ans_cnt          <= '0;
`endif
          end
        end
        WAIT_ANS: begin
          if (start_evt) begin
            p_DataReceived_o <= 1'b1;
            state            <= tx_busy_i ? TX_ACTIVE : IDLE;
          end else if (tx_busy_i) begin
            state <= TX_ACTIVE;
          end
`ifdef ANS_TIMEOUT_EN
          else if (p_sig_10MHz_o) begin
            ans_cnt <= ans_cnt + 16'd1;
            if (ans_cnt + 16'd1 == TIMEOUT_N) begin
              timeout_q <= 1'b1;
              state     <= IDLE;
            end
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx_armed_o = (state == WAIT_ANS);

endmodule

// File: tb/tb_ans_delay_event_gen.sv
// Self-checking bench for ans_delay_event_gen: directed scenarios plus random stimulus against a reference model.
module tb_ans_delay_event_gen;

  localparam longint CLK_HZ  = 40_000_000;
  localparam longint TICK_HZ = 10_000_000;
  localparam int     FL      = 3;
  localparam int     TO      = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx_busy = 1'b0;
  logic tx_fifo_empty = 1'b1;
  logic rx = 1'b1;
  logic p_tick, p_send, p_data, armed, p_to;

  ans_delay_event_gen #(
    .CLK_FREQ_HZ  (40_000_000),
    .TICK_FREQ_HZ (10_000_000),
    .FILTER_LEN   (FL),
    .TIMEOUT_TICKS(TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .tx_busy_i       (tx_busy),
    .tx_fifo_empty_i (tx_fifo_empty),
    .rx_i            (rx),
    .p_sig_10MHz_o   (p_tick),
    .p_SendFinished_o(p_send),
    .p_DataReceived_o(p_data),
    .rx_armed_o      (armed),
    .p_timeout_o     (p_to)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [4:0] v;   // {tick, send, data, armed, timeout}
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model state
  longint n_run = 0;           // edges since reset released
  int     dly[$] = '{1, 1};    // synchronizer delay line, post-reset contents
  int     win[$];              // last FL synchronized samples
  int     level = 1;
  bit     fell = 1'b0;
  int     mst = 0;             // 0 idle, 1 sending, 2 awaiting answer
  int     ticks_waited = 0;
  bit     tick_cur = 1'b0;

  task automatic model_edge();
    exp_t e;
    bit   tick_nxt, start, snd, dat, tmo, differ;
    int   fin;
    snd = 0; dat = 0; tmo = 0;
    cyc++;
    if (!rst) begin
      n_run = 0; dly = '{1, 1}; win = {}; level = 1; fell = 0;
      mst = 0; ticks_waited = 0; tick_cur = 0;
      e.v = 5'b0;
    end else begin
      n_run++;
      tick_nxt = ((n_run * TICK_HZ) / CLK_HZ) != (((n_run - 1) * TICK_HZ) / CLK_HZ);
      start = fell;
      fin = dly.pop_front();
      dly.push_back(int'(rx));
      win.push_back(fin);
      if (win.size() > FL) void'(win.pop_front());
      fell = 0;
      if (win.size() == FL) begin
        differ = 1;
        foreach (win[i]) if (win[i] == level) differ = 0;
        if (differ) begin
          level = 1 - level;
          fell = (level == 0);
        end
      end
      case (mst)
        0: if (tx_busy) mst = 1;
        1: if (!tx_busy && tx_fifo_empty) begin snd = 1; mst = 2; ticks_waited = 0; end
        default: begin
          if (start) begin dat = 1; mst = tx_busy ? 1 : 0; end
          else if (tx_busy) mst = 1;
`ifdef ANS_TIMEOUT_EN
          else if (tick_cur) begin
            ticks_waited++;
            if (ticks_waited == TO) begin tmo = 1; mst = 0; end
          end
`endif
        end
      endcase
      tick_cur = tick_nxt;
      e.v = {tick_nxt, snd, dat, (mst == 2), tmo};
    end
    e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Monitor: pops the expectation for each edge and compares it half a cycle later.
  initial begin
    exp_t       e;
    logic [4:0] got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {p_tick, p_send, p_data, armed, p_to};
        checks++;
        if (got !== e.v) begin
          errors++;
          $display("FAIL outputs cycle %0d: got {tick,send,data,armed,to}=%b, expected %b", e.cyc, got, e.v);
        end
        checks++;
        if (p_send === 1'b1 && p_data === 1'b1) begin
          errors++;
          $display("FAIL exclusive_pulses cycle %0d: send=%b data=%b, expected not both 1", e.cyc, p_send, p_data);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int kind, len;
    // Reset, then free-running ticks with everything else quiet.
    rst = 0; tx_busy = 0; tx_fifo_empty = 1; rx = 1;
    run(2);
    rst = 1;
    run(40);
    // Single-byte command and answer.
    tx_busy = 1; run(20);
    tx_busy = 0; tx_fifo_empty = 1; run(3);
    rx = 0; run(10);
    rx = 1; run(10);
    // Two-byte command with inter-byte gap.
    tx_busy = 1; run(10);
    tx_busy = 0; tx_fifo_empty = 0; run(3);
    tx_busy = 1; run(10);
    tx_busy = 0; tx_fifo_empty = 1; run(3);
    // Glitches, then a real start bit, then later start bits.
    rx = 0; run(2);
    rx = 1; run(3);
    rx = 0; run(1);
    rx = 1; run(5);
    rx = 0; run(8);
    rx = 1; run(5);
    rx = 0; run(6);
    rx = 1; run(6);
    // Silent answer window.
    tx_busy = 1; run(5);
    tx_busy = 0; run(1100);
    // Reset during the answer window while rx falls.
    tx_busy = 1; run(5);
    tx_busy = 0; run(5);
    rx = 0; run(2);
    rst = 0; run(1);
    rst = 1; run(20);
    rx = 1; run(10);
    // Randomized traffic.
    repeat (350) begin
      kind = $urandom_range(0, 19);
      if (kind < 8) begin
        tx_busy = 1; run($urandom_range(1, 15));
        tx_busy = 0; tx_fifo_empty = 1'($urandom_range(0, 1)); run($urandom_range(1, 10));
      end else if (kind < 16) begin
        rx = ~rx; run($urandom_range(1, 8));
      end else if (kind < 19) begin
        len = $urandom_range(1, 6);
        repeat (len) begin
          tx_busy = 1'($urandom_range(0, 1));
          tx_fifo_empty = 1'($urandom_range(0, 1));
          rx = 1'($urandom_range(0, 1));
          step();
        end
      end else begin
        rst = 0; run($urandom_range(1, 2));
        rst = 1;
      end
    end
    tx_busy = 0; rx = 1; run(4);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
